// File: rtl/mem_writeback_stage.sv
// Final pipeline stage: data-memory access over req/gnt/rvalid, load alignment/extension,
// writeback source selection and exactly one register-file write per retiring instruction.
module mem_writeback_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_reg_we,
    input  logic [4:0]  ex_rd,
    input  logic [1:0]  ex_wb_sel,
    input  logic        ex_is_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_csr_rdata,
    input  logic [31:0] ex_store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        misalign_err,
    output logic        bus_err
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT_RESP = 2'd2} state_t;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b000, 3'b100: is_misaligned = 1'b0;
            3'b001, 3'b101: is_misaligned = a[0];
            3'b010:         is_misaligned = (a != 2'b00);
            default:        is_misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   byte_enables = 4'b0001 << a;
            2'b01:   byte_enables = 4'b0011 << a;
            default: byte_enables = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   store_lanes = {4{d[7:0]}};
            2'b01:   store_lanes = {2{d[15:0]}};
            default: store_lanes = d;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] w);
        logic [31:0] s;
        s = w >> {a, 3'b000};
        case (f3)
            3'b000:  load_extend = {{24{s[7]}}, s[7:0]};
            3'b001:  load_extend = {{16{s[15]}}, s[15:0]};
            3'b100:  load_extend = {24'd0, s[7:0]};
            3'b101:  load_extend = {16'd0, s[15:0]};
            default: load_extend = s;
        endcase
    endfunction

    state_t          state_r, state_next_s;
    logic [CW-1:0]   cnt_r;
    logic [4:0]      rd_r;
    logic            reg_we_r, is_load_r, kill_r;
    logic [2:0]      f3_r;
    logic [1:0]      off_r;
    logic            accept_s, is_mem_s, misalign_s, mem_start_s, cnt_last_s;
    logic            done_s, timeout_s, abort_s, kill_now_s;
    logic [31:0]     wb_data_s;

    assign ex_ready    = (state_r == IDLE);
    assign accept_s    = (state_r == IDLE) && ex_valid && !flush;
    assign is_mem_s    = ex_is_store || (ex_wb_sel == 2'd1);
    assign misalign_s  = is_misaligned(ex_funct3, ex_alu_result[1:0]);
    assign mem_start_s = accept_s && is_mem_s && !misalign_s;
    assign cnt_last_s  = (cnt_r == CW'(TIMEOUT_CYCLES - 1));
    // A flush seen at any point of the access kills its register write.
    assign kill_now_s  = kill_r || flush;

    // Writeback source for non-memory instructions.
    always_comb begin
        wb_data_s = ex_alu_result;
        case (ex_wb_sel)
            2'd2:    wb_data_s = ex_pc + 32'd4;
            2'd3:    wb_data_s = ex_csr_rdata;
            default: wb_data_s = ex_alu_result;
        endcase
    end

    // Next-state logic and access completion/abort events.
    always_comb begin
        state_next_s = state_r;
        done_s       = 1'b0;
        timeout_s    = 1'b0;
        abort_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_start_s) state_next_s = REQ;
                else             state_next_s = IDLE;
            end
            REQ: begin
                if (dmem_gnt) begin
                    if (dmem_rvalid) begin
                        state_next_s = IDLE;
                        done_s       = 1'b1;
                    end else begin
                        state_next_s = WAIT_RESP;
                    end
                end else if (flush) begin
                    state_next_s = IDLE;
                    abort_s      = 1'b1;
                end else if (cnt_last_s) begin
                    state_next_s = IDLE;
                    timeout_s    = 1'b1;
                end else begin
                    state_next_s = REQ;
                end
            end
            WAIT_RESP: begin
                if (dmem_rvalid) begin
                    state_next_s = IDLE;
                    done_s       = 1'b1;
                end else if (cnt_last_s) begin
                    state_next_s = IDLE;
                    timeout_s    = 1'b1;
                end else begin
                    state_next_s = WAIT_RESP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_next_s;
    end

    // Bus request, access context, error pulses and register-file write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= 32'd0;
            dmem_wdata   <= 32'd0;
            dmem_be      <= 4'd0;
            rf_we        <= 1'b0;
            rf_waddr     <= 5'd0;
            rf_wdata     <= 32'd0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            cnt_r        <= '0;
            rd_r         <= 5'd0;
            reg_we_r     <= 1'b0;
            is_load_r    <= 1'b0;
            kill_r       <= 1'b0;
            f3_r         <= 3'd0;
            off_r        <= 2'd0;
        end else begin
            rf_we        <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            if (accept_s && !is_mem_s && ex_reg_we && (ex_rd != 5'd0)) begin
                rf_we    <= 1'b1;
                rf_waddr <= ex_rd;
                rf_wdata <= wb_data_s;
            end
            if (accept_s && is_mem_s && misalign_s) begin
                misalign_err <= 1'b1;
            end
            if (mem_start_s) begin
                dmem_req   <= 1'b1;
                dmem_we    <= ex_is_store;
                dmem_addr  <= {ex_alu_result[31:2], 2'b00};
                dmem_wdata <= store_lanes(ex_funct3, ex_store_data);
                dmem_be    <= byte_enables(ex_funct3, ex_alu_result[1:0]);
                cnt_r      <= '0;
                rd_r       <= ex_rd;
                reg_we_r   <= ex_reg_we;
                is_load_r  <= !ex_is_store;
                kill_r     <= 1'b0;
                f3_r       <= ex_funct3;
                off_r      <= ex_alu_result[1:0];
            end else if (state_r != IDLE) begin
                cnt_r  <= cnt_r + CW'(1);
                kill_r <= kill_now_s;
                if (((state_r == REQ) && dmem_gnt) || abort_s || timeout_s) begin
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                end
                if (timeout_s) begin
                    bus_err <= 1'b1;
                end
                if (done_s && is_load_r && reg_we_r && (rd_r != 5'd0) && !kill_now_s) begin
                    rf_we    <= 1'b1;
                    rf_waddr <= rd_r;
                    rf_wdata <= load_extend(f3_r, off_r, dmem_rdata);
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_writeback_stage.sv
// Bench for mem_writeback_stage: vector table with a writeback scoreboard, plus
// hand-written sequences for timeout, flush, same-cycle gnt/rvalid and reset mid-access.
module tb_mem_writeback_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0, ex_valid = 1'b0, ex_ready, ex_reg_we = 1'b0, ex_is_store = 1'b0;
    logic [4:0]  ex_rd = 5'd0;
    logic [1:0]  ex_wb_sel = 2'd0;
    logic [2:0]  ex_funct3 = 3'd0;
    logic [31:0] ex_alu_result = 32'd0, ex_pc = 32'd0, ex_csr_rdata = 32'd0, ex_store_data = 32'd0;
    logic        dmem_req, dmem_we, dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 32'd0;
    logic [3:0]  dmem_be;
    logic        rf_we, misalign_err, bus_err;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int total = 0;
    int bad = 0;
    logic [36:0] sb[$];
    logic [36:0] mon_e;

    typedef struct {
        logic        reg_we;
        logic [4:0]  rd;
        logic [1:0]  wb_sel;
        logic        is_store;
        logic [2:0]  f3;
        logic [31:0] alu, pc, csr, sdata, rdata;
        logic        exp_mis;
        logic        exp_we;
        logic [31:0] exp_data, exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_bwdata;
    } vec_t;
    vec_t vt[16];

    mem_writeback_stage #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_reg_we(ex_reg_we), .ex_rd(ex_rd), .ex_wb_sel(ex_wb_sel), .ex_is_store(ex_is_store),
        .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result), .ex_pc(ex_pc),
        .ex_csr_rdata(ex_csr_rdata), .ex_store_data(ex_store_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every register-file write must match the oldest expected write.
    always @(posedge clk) begin
        #1;
        if (rf_we === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rf_unexpected actual=we1 waddr=%0d wdata=%h required=no write",
                         rf_waddr, rf_wdata);
            end else begin
                mon_e = sb.pop_front();
                chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, mon_e[36:32]});
                chk("rf_wdata", rf_wdata, mon_e[31:0]);
            end
        end
    end

    task automatic drive(input vec_t v);
        ex_valid      = 1'b1;
        ex_reg_we     = v.reg_we;
        ex_rd         = v.rd;
        ex_wb_sel     = v.wb_sel;
        ex_is_store   = v.is_store;
        ex_funct3     = v.f3;
        ex_alu_result = v.alu;
        ex_pc         = v.pc;
        ex_csr_rdata  = v.csr;
        ex_store_data = v.sdata;
        if (v.exp_we) sb.push_back({v.rd, v.exp_data});
    endtask

    task automatic run_vec(input vec_t v);
        logic is_mem;
        is_mem = v.is_store || (v.wb_sel == 2'd1);
        drive(v);
        step();
        ex_valid = 1'b0;
        if (v.exp_mis) begin
            chk("mis_pulse", {31'd0, misalign_err}, 32'd1);
            chk("mis_noreq", {31'd0, dmem_req}, 32'd0);
            chk("mis_ready", {31'd0, ex_ready}, 32'd1);
            step();
            chk("mis_once", {31'd0, misalign_err}, 32'd0);
        end else if (is_mem) begin
            chk("req", {31'd0, dmem_req}, 32'd1);
            chk("we", {31'd0, dmem_we}, {31'd0, v.is_store});
            chk("addr", dmem_addr, v.exp_addr);
            chk("busy", {31'd0, ex_ready}, 32'd0);
            if (v.is_store) begin
                chk("be", {28'd0, dmem_be}, {28'd0, v.exp_be});
                chk("bwdata", dmem_wdata, v.exp_bwdata);
            end
            dmem_gnt = 1'b1;
            step();
            dmem_gnt = 1'b0;
            chk("req_drop", {31'd0, dmem_req}, 32'd0);
            chk("busy_wait", {31'd0, ex_ready}, 32'd0);
            dmem_rvalid = 1'b1;
            dmem_rdata  = v.rdata;
            step();
            dmem_rvalid = 1'b0;
            chk("ready_back", {31'd0, ex_ready}, 32'd1);
        end else begin
            chk("nomem_ready", {31'd0, ex_ready}, 32'd1);
        end
        step();
    endtask

    task automatic start_lw(input logic [31:0] addr, input logic [4:0] rd);
        vec_t v;
        v = '{1'b1, rd, 2'd1, 1'b0, 3'b010, addr, 32'd0, 32'd0, 32'd0, 32'd0,
              1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 32'd0};
        drive(v);
        step();
        ex_valid = 1'b0;
    endtask

    initial begin
        int n;
        vt[0]  = '{1'b1, 5'd5,  2'd0, 1'b0, 3'd0, 32'h0000_1234, 32'h0000_2000, 32'h5555_AAAA, 32'd0, 32'd0,
                   1'b0, 1'b1, 32'h0000_1234, 32'd0, 4'd0, 32'd0};
        vt[1]  = '{1'b1, 5'd0,  2'd0, 1'b0, 3'd0, 32'h0000_0042, 32'd0, 32'd0, 32'd0, 32'd0,
                   1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 32'd0};
        vt[2]  = '{1'b1, 5'd3,  2'd2, 1'b0, 3'd0, 32'h0000_0077, 32'h0000_1000, 32'h1111_1111, 32'd0, 32'd0,
                   1'b0, 1'b1, 32'h0000_1004, 32'd0, 4'd0, 32'd0};
        vt[3]  = '{1'b1, 5'd31, 2'd3, 1'b0, 3'd0, 32'h0000_0077, 32'h0000_1000, 32'hDEAD_BEEF, 32'd0, 32'd0,
                   1'b0, 1'b1, 32'hDEAD_BEEF, 32'd0, 4'd0, 32'd0};
        vt[4]  = '{1'b0, 5'd4,  2'd0, 1'b0, 3'd0, 32'h0000_0099, 32'd0, 32'd0, 32'd0, 32'd0,
                   1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 32'd0};
        vt[5]  = '{1'b1, 5'd7,  2'd1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'd0, 32'd0, 32'h80FF_FFFF,
                   1'b0, 1'b1, 32'hFFFF_FF80, 32'h0000_0100, 4'd0, 32'd0};
        vt[6]  = '{1'b1, 5'd7,  2'd1, 1'b0, 3'b100, 32'h0000_0103, 32'd0, 32'd0, 32'd0, 32'h80FF_FFFF,
                   1'b0, 1'b1, 32'h0000_0080, 32'h0000_0100, 4'd0, 32'd0};
        vt[7]  = '{1'b1, 5'd8,  2'd1, 1'b0, 3'b001, 32'h0000_0102, 32'd0, 32'd0, 32'd0, 32'h8001_1234,
                   1'b0, 1'b1, 32'hFFFF_8001, 32'h0000_0100, 4'd0, 32'd0};
        vt[8]  = '{1'b1, 5'd8,  2'd1, 1'b0, 3'b101, 32'h0000_0102, 32'd0, 32'd0, 32'd0, 32'h8001_1234,
                   1'b0, 1'b1, 32'h0000_8001, 32'h0000_0100, 4'd0, 32'd0};
        vt[9]  = '{1'b1, 5'd9,  2'd1, 1'b0, 3'b010, 32'h0000_0200, 32'd0, 32'd0, 32'd0, 32'hCAFE_F00D,
                   1'b0, 1'b1, 32'hCAFE_F00D, 32'h0000_0200, 4'd0, 32'd0};
        vt[10] = '{1'b1, 5'd6,  2'd0, 1'b1, 3'b001, 32'h0000_0102, 32'd0, 32'd0, 32'h0000_ABCD, 32'h1234_5678,
                   1'b0, 1'b0, 32'd0, 32'h0000_0100, 4'b1100, 32'hABCD_ABCD};
        vt[11] = '{1'b1, 5'd6,  2'd0, 1'b1, 3'b000, 32'h0000_0101, 32'd0, 32'd0, 32'h1234_5677, 32'd0,
                   1'b0, 1'b0, 32'd0, 32'h0000_0100, 4'b0010, 32'h7777_7777};
        vt[12] = '{1'b1, 5'd6,  2'd0, 1'b1, 3'b010, 32'h0000_0104, 32'd0, 32'd0, 32'h1122_3344, 32'd0,
                   1'b0, 1'b0, 32'd0, 32'h0000_0104, 4'b1111, 32'h1122_3344};
        vt[13] = '{1'b1, 5'd9,  2'd1, 1'b0, 3'b010, 32'h0000_0101, 32'd0, 32'd0, 32'd0, 32'd0,
                   1'b1, 1'b0, 32'd0, 32'd0, 4'd0, 32'd0};
        vt[14] = '{1'b1, 5'd9,  2'd1, 1'b0, 3'b001, 32'h0000_0103, 32'd0, 32'd0, 32'd0, 32'd0,
                   1'b1, 1'b0, 32'd0, 32'd0, 4'd0, 32'd0};
        vt[15] = '{1'b1, 5'd9,  2'd1, 1'b0, 3'b011, 32'h0000_0100, 32'd0, 32'd0, 32'd0, 32'd0,
                   1'b1, 1'b0, 32'd0, 32'd0, 4'd0, 32'd0};

        step();
        step();
        chk("rst_ready", {31'd0, ex_ready}, 32'd1);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_rfwe", {31'd0, rf_we}, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_rfwdata", rf_wdata, 32'd0);
        rst = 1'b0;
        step();

        // Exact one-cycle latency for an ALU op, then hold of write data.
        drive(vt[0]);
        step();
        ex_valid = 1'b0;
        chk("alu_lat_we", {31'd0, rf_we}, 32'd1);
        chk("alu_lat_data", rf_wdata, 32'h0000_1234);
        step();
        chk("alu_one_cycle", {31'd0, rf_we}, 32'd0);
        chk("wdata_hold", rf_wdata, 32'h0000_1234);

        for (int i = 0; i < 16; i++) run_vec(vt[i]);

        // Grant withheld: timeout after 16 cycles in REQ, late rvalid ignored.
        start_lw(32'h0000_0300, 5'd10);
        n = 0;
        while (dmem_req === 1'b1 && n < 40) begin
            n++;
            step();
        end
        chk("timeout_cycles", n, 32'd16);
        chk("bus_err_pulse", {31'd0, bus_err}, 32'd1);
        chk("timeout_ready", {31'd0, ex_ready}, 32'd1);
        step();
        chk("bus_err_once", {31'd0, bus_err}, 32'd0);
        step();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1234_5678;
        step();
        dmem_rvalid = 1'b0;
        chk("late_rvalid_ready", {31'd0, ex_ready}, 32'd1);
        step();

        // Flush during WAIT_RESP: access completes, no register write.
        start_lw(32'h0000_0100, 5'd11);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_wait_busy", {31'd0, ex_ready}, 32'd0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hAAAA_5555;
        step();
        dmem_rvalid = 1'b0;
        chk("flush_wait_ready", {31'd0, ex_ready}, 32'd1);
        step();

        // Flush in REQ before grant aborts without error.
        start_lw(32'h0000_0100, 5'd12);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_req_drop", {31'd0, dmem_req}, 32'd0);
        chk("flush_req_ready", {31'd0, ex_ready}, 32'd1);
        chk("flush_req_noerr", {31'd0, bus_err}, 32'd0);

        // Flush together with ex_valid discards the instruction.
        flush = 1'b1;
        drive('{1'b1, 5'd12, 2'd0, 1'b0, 3'd0, 32'h0000_0BAD, 32'd0, 32'd0, 32'd0, 32'd0,
                1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 32'd0});
        step();
        flush = 1'b0;
        ex_valid = 1'b0;
        chk("flush_idle_noreq", {31'd0, dmem_req}, 32'd0);

        // Grant and rvalid in the same cycle.
        sb.push_back({5'd13, 32'h0000_0055});
        start_lw(32'h0000_0400, 5'd13);
        dmem_gnt    = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h0000_0055;
        step();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        chk("gnt_rvalid_ready", {31'd0, ex_ready}, 32'd1);
        chk("gnt_rvalid_we", {31'd0, rf_we}, 32'd1);
        step();

        // Reset asserted in WAIT_RESP clears everything at once.
        start_lw(32'h0000_0500, 5'd14);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_ready", {31'd0, ex_ready}, 32'd1);
        chk("rst_mid_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_mid_addr", dmem_addr, 32'd0);
        chk("rst_mid_rfwdata", rf_wdata, 32'd0);
        chk("rst_mid_berr", {31'd0, bus_err}, 32'd0);
        step();
        rst = 1'b0;
        step();
        step();

        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
